// File: rtl/dsp_pipe_delay_if.sv
// Handshake and data bundle for the DSP pipeline delay line.
// The master drives the stream and the tap select; the slave returns the delayed data, taps and occupancy.
interface dsp_pipe_delay_if #(
    parameter int WIDTH = 18,
    parameter int TAPW  = 4,
    parameter int OCCW  = 4
);
    logic             CEIN;
    logic             SCLR;
    logic             VIN;
    logic [WIDTH-1:0] IN;
    logic [TAPW-1:0]  TAPSEL;
    logic [WIDTH-1:0] OUT;
    logic             VOUT;
    logic [WIDTH-1:0] TAP;
    logic             VTAP;
    logic [OCCW-1:0]  OCC;

    modport master (
        output CEIN, SCLR, VIN, IN, TAPSEL,
        input  OUT, VOUT, TAP, VTAP, OCC
    );

    modport slave (
        input  CEIN, SCLR, VIN, IN, TAPSEL,
        output OUT, VOUT, TAP, VTAP, OCC
    );
endinterface

// File: rtl/dsp_pipe_delay.sv
// Configurable 0..8-stage delay line with a valid chain, synchronous flush,
// selectable tap and occupancy counter, used to balance DSP slice operand latency.
module dsp_pipe_delay #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    parameter int TAPW  = 4,
    parameter int OCCW  = 4
) (
    input  logic             CLK,
    input  logic             RSTIN_N,
    dsp_pipe_delay_if.slave  bus
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Pure wire path: no state, so clock, reset, enable and flush are unused.
            logic unused_inputs;
            assign unused_inputs = &{1'b0, CLK, RSTIN_N, bus.CEIN, bus.SCLR, bus.TAPSEL};

            assign bus.OUT  = bus.IN;
            assign bus.VOUT = bus.VIN;
            assign bus.TAP  = bus.IN;
            assign bus.VTAP = bus.VIN;
            assign bus.OCC  = '0;
        end else begin : g_pipe
            logic [WIDTH-1:0] s [DEPTH];
            logic [DEPTH-1:0] v;
            logic [OCCW-1:0]  occ;
            logic [WIDTH-1:0] tap_d;
            logic             tap_v;
            int               tap_sel;

            // Occupancy moves by what enters minus what leaves on each advancing edge.
            always_ff @(posedge CLK or negedge RSTIN_N) begin
                if (!RSTIN_N) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        s[k] <= '0;
                    end
                    v   <= '0;
                    occ <= '0;
                end else if (bus.SCLR) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        s[k] <= '0;
                    end
                    v   <= '0;
                    occ <= '0;
                end else if (bus.CEIN) begin
                    s[0] <= bus.IN;
                    v[0] <= bus.VIN;
                    for (int k = 1; k < DEPTH; k++) begin
                        s[k] <= s[k-1];
                        v[k] <= v[k-1];
                    end
                    occ <= occ + OCCW'(bus.VIN) - OCCW'(v[DEPTH-1]);
                end
            end

            // Tap 0 is the live input; selects beyond the last stage clamp to it.
            always_comb begin
                tap_sel = int'(bus.TAPSEL);
                if (tap_sel > DEPTH) begin
                    tap_sel = DEPTH;
                end
                tap_d = bus.IN;
                tap_v = bus.VIN;
                for (int k = 0; k < DEPTH; k++) begin
                    if (tap_sel == k + 1) begin
                        tap_d = s[k];
                        tap_v = v[k];
                    end
                end
            end

            assign bus.OUT  = s[DEPTH-1];
            assign bus.VOUT = v[DEPTH-1];
            assign bus.TAP  = tap_d;
            assign bus.VTAP = tap_v;
            assign bus.OCC  = occ;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// Bench for dsp_pipe_delay: directed scenarios plus randomized traffic against a queue model,
// with a pass-through DEPTH=0 instance exercised alongside.
module tb_dsp_pipe_delay;

    localparam int WIDTH = 18;
    localparam int DEPTH = 3;
    localparam int TAPW  = 4;
    localparam int OCCW  = 4;

    logic CLK     = 1'b0;
    logic RSTIN_N = 1'b1;
    logic rst0_n  = 1'b1;
    logic cmp_en  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dsp_pipe_delay_if #(.WIDTH(WIDTH), .TAPW(TAPW), .OCCW(OCCW)) bus ();
    dsp_pipe_delay_if #(.WIDTH(WIDTH), .TAPW(TAPW), .OCCW(OCCW)) bus0 ();

    dsp_pipe_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW), .OCCW(OCCW)) dut (
        .CLK     (CLK),
        .RSTIN_N (RSTIN_N),
        .bus     (bus)
    );

    dsp_pipe_delay #(.WIDTH(WIDTH), .DEPTH(0), .TAPW(TAPW), .OCCW(OCCW)) dut0 (
        .CLK     (CLK),
        .RSTIN_N (rst0_n),
        .bus     (bus0)
    );

    always #5 CLK = ~CLK;

    // Model: queue of {valid,data}, element 0 is the youngest stage.
    logic [WIDTH:0] mq [$];

    function automatic void clearModel();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mq.push_back('0);
        end
    endfunction

    function automatic int modelOcc();
        int n = 0;
        foreach (mq[i]) n += int'(mq[i][WIDTH]);
        return n;
    endfunction

    function automatic logic [WIDTH:0] modelTap();
        int sel = int'(bus.TAPSEL);
        if (sel > DEPTH) sel = DEPTH;
        if (sel == 0) return {bus.VIN, bus.IN};
        return mq[sel-1];
    endfunction

    always @(posedge CLK or negedge RSTIN_N) begin
        if (!RSTIN_N) begin
            clearModel();
        end else if (bus.SCLR) begin
            clearModel();
        end else if (bus.CEIN) begin
            mq.push_front({bus.VIN, bus.IN});
            void'(mq.pop_back());
        end
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic sclr, input logic vin,
                                 input logic [WIDTH-1:0] din, input logic [TAPW-1:0] sel);
        bus.CEIN   = ce;
        bus.SCLR   = sclr;
        bus.VIN    = vin;
        bus.IN     = din;
        bus.TAPSEL = sel;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every falling edge, both instances are compared with the model.
    logic [WIDTH:0] mtap;
    always @(negedge CLK) begin
        if (cmp_en) begin
            mtap = modelTap();
            checkOutput("out",  48'(bus.OUT),  48'(mq[DEPTH-1][WIDTH-1:0]));
            checkOutput("vout", 48'(bus.VOUT), 48'(mq[DEPTH-1][WIDTH]));
            checkOutput("occ",  48'(bus.OCC),  48'(modelOcc()));
            checkOutput("tap",  48'(bus.TAP),  48'(mtap[WIDTH-1:0]));
            checkOutput("vtap", 48'(bus.VTAP), 48'(mtap[WIDTH]));
            checkOutput("d0_out",  48'(bus0.OUT),  48'(bus0.IN));
            checkOutput("d0_vout", 48'(bus0.VOUT), 48'(bus0.VIN));
            checkOutput("d0_tap",  48'(bus0.TAP),  48'(bus0.IN));
            checkOutput("d0_vtap", 48'(bus0.VTAP), 48'(bus0.VIN));
            checkOutput("d0_occ",  48'(bus0.OCC),  48'd0);
        end
    end

    int selv [5] = '{0, 1, 2, 3, 7};
    int tapx [5] = '{9, 5, 6, 7, 7};
    int vtx  [5] = '{1, 1, 0, 1, 1};

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h3FFFF, 4'd0);
        bus0.CEIN = 1'b0; bus0.SCLR = 1'b0; bus0.VIN = 1'b1; bus0.IN = 18'h3FFFF; bus0.TAPSEL = 4'd0;

        // Asynchronous reset, checked before any clock edge
        #1 RSTIN_N = 1'b0;
        #2;
        checkOutput("rst_out",  48'(bus.OUT),  48'd0);
        checkOutput("rst_vout", 48'(bus.VOUT), 48'd0);
        checkOutput("rst_occ",  48'(bus.OCC),  48'd0);
        checkOutput("d0_same_out",  48'(bus0.OUT),  48'h3FFFF);
        checkOutput("d0_same_vout", 48'(bus0.VOUT), 48'd1);
        bus0.CEIN = 1'b1; bus0.SCLR = 1'b1; rst0_n = 1'b0; bus0.TAPSEL = 4'd5;
        #1;
        checkOutput("d0_toggle_out", 48'(bus0.OUT), 48'h3FFFF);
        checkOutput("d0_toggle_tap", 48'(bus0.TAP), 48'h3FFFF);
        checkOutput("d0_toggle_occ", 48'(bus0.OCC), 48'd0);
        @(posedge CLK);
        #1;
        RSTIN_N = 1'b1;
        rst0_n  = 1'b1;
        cmp_en  = 1'b1;

        // Fill sequence 1..4
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd1, 4'd0); tick();
        checkOutput("fill1_occ",  48'(bus.OCC),  48'd1);
        checkOutput("fill1_vout", 48'(bus.VOUT), 48'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd2, 4'd0); tick();
        checkOutput("fill2_occ",  48'(bus.OCC),  48'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd3, 4'd0); tick();
        checkOutput("fill3_out",  48'(bus.OUT),  48'd1);
        checkOutput("fill3_vout", 48'(bus.VOUT), 48'd1);
        checkOutput("fill3_occ",  48'(bus.OCC),  48'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd4, 4'd0); tick();
        checkOutput("fill4_out", 48'(bus.OUT), 48'd2);
        checkOutput("fill4_occ", 48'(bus.OCC), 48'd3);

        // Stall: chain {4,3,2} must freeze while IN changes
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h2AAAA, 4'd0); tick(); tick();
        checkOutput("stall_out", 48'(bus.OUT), 48'd2);
        checkOutput("stall_occ", 48'(bus.OCC), 48'd3);
        for (int i = 1; i <= 3; i++) begin
            bus.TAPSEL = TAPW'(i);
            #1;
            checkOutput("stall_tap", 48'(bus.TAP), 48'(5 - i));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 18'h2AAAA, 4'd0); tick();
        checkOutput("resume_out3", 48'(bus.OUT), 48'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd5, 4'd0); tick();
        checkOutput("resume_out4", 48'(bus.OUT), 48'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd6, 4'd0); tick();
        checkOutput("resume_outA", 48'(bus.OUT), 48'h2AAAA);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd7, 4'd0); tick();
        checkOutput("resume_out5", 48'(bus.OUT), 48'd5);

        // Flush with a full chain and a valid input on the same edge
        applyStimulus(1'b1, 1'b1, 1'b1, 18'h12345, 4'd0); tick();
        checkOutput("sclr_out",  48'(bus.OUT),  48'd0);
        checkOutput("sclr_vout", 48'(bus.VOUT), 48'd0);
        checkOutput("sclr_occ",  48'(bus.OCC),  48'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 18'd0, 4'd0); tick();
            checkOutput("sclr_drain_out", 48'(bus.OUT), 48'd0);
        end

        // Tap sweep with s = {5,6,7} and v = {1,0,1}
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd7, 4'd0); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 18'd6, 4'd0); tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 18'd5, 4'd0); tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 18'd9, 4'd0);
        checkOutput("sweep_occ", 48'(bus.OCC), 48'd2);
        for (int i = 0; i < 5; i++) begin
            bus.TAPSEL = TAPW'(selv[i]);
            #1;
            checkOutput("sweep_tap",  48'(bus.TAP),  48'(tapx[i]));
            checkOutput("sweep_vtap", 48'(bus.VTAP), 48'(vtx[i]));
        end

        // Asynchronous reset mid-stream, then refill from empty
        applyStimulus(1'b1, 1'b0, 1'b1, 18'hA, 4'd0); tick(); tick();
        #2 RSTIN_N = 1'b0;
        #1;
        checkOutput("midrst_out",  48'(bus.OUT),  48'd0);
        checkOutput("midrst_vout", 48'(bus.VOUT), 48'd0);
        checkOutput("midrst_occ",  48'(bus.OCC),  48'd0);
        @(posedge CLK);
        #1;
        RSTIN_N = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 18'h11, 4'd0); tick(); tick();
        checkOutput("refill_vout", 48'(bus.VOUT), 48'd0);
        checkOutput("refill_occ",  48'(bus.OCC),  48'd2);
        tick();
        checkOutput("refill_out",  48'(bus.OUT),  48'h11);
        checkOutput("refill_vout3", 48'(bus.VOUT), 48'd1);

        // Randomized traffic, compared by the falling-edge process
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            RSTIN_N = 1'b1;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 1'($urandom),
                          WIDTH'($urandom), TAPW'($urandom));
            bus0.CEIN   = 1'($urandom);
            bus0.SCLR   = 1'($urandom);
            bus0.VIN    = 1'($urandom);
            bus0.IN     = WIDTH'($urandom);
            bus0.TAPSEL = TAPW'($urandom);
            rst0_n      = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 RSTIN_N = 1'b0;
            end
        end

        @(posedge CLK);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
